// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with an integrated busy-bit scoreboard.
// Read ports are combinational with same-cycle writeback bypass; decode uses
// rd_busy / alloc_ok to detect RAW and WAW hazards before issue.
module regfile_sb #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int NREAD = 3,
  localparam int AW = $clog2(NREGS),
  localparam int CW = $clog2(NREGS + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREAD*AW-1:0]    rd_addr,
  output logic [NREAD*WIDTH-1:0] rd_data,
  output logic [NREAD-1:0]       rd_busy,
  input  logic                   alloc_valid,
  input  logic [AW-1:0]          alloc_dest,
  output logic                   alloc_ok,
  input  logic                   wb_valid,
  input  logic [AW-1:0]          wb_dest,
  input  logic [WIDTH-1:0]       wb_data,
  output logic [CW-1:0]          busy_count
);

  logic [WIDTH-1:0] r_data [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [CW-1:0]    r_count;

  logic             w_dest_free;
  logic [NREGS-1:0] w_busy_next;
  logic [CW-1:0]    w_count_next;

  // A writeback to the requested destination this cycle frees it for a new producer.
  assign w_dest_free = ~r_busy[alloc_dest] | (wb_valid & (wb_dest == alloc_dest));
  assign alloc_ok    = alloc_valid & w_dest_free;
  assign busy_count  = r_count;

  // Independent read ports: bypass the in-flight writeback, else read the array.
  genvar gi;
  generate
    for (gi = 0; gi < NREAD; gi++) begin : g_rd
      logic [AW-1:0] w_addr;
      logic          w_hit;
      assign w_addr = rd_addr[gi*AW +: AW];
      assign w_hit  = wb_valid & (wb_dest == w_addr);
      assign rd_data[gi*WIDTH +: WIDTH] = w_hit ? wb_data : r_data[w_addr];
      assign rd_busy[gi] = r_busy[w_addr] & ~w_hit;
    end
  endgenerate

  // Next busy vector: allocation wins over a same-cycle writeback clear.
  always_comb begin
    w_busy_next = r_busy;
    for (int r = 0; r < NREGS; r++) begin
      if (alloc_ok && (alloc_dest == AW'(r))) begin
        w_busy_next[r] = 1'b1;
      end else if (wb_valid && (wb_dest == AW'(r))) begin
        w_busy_next[r] = 1'b0;
      end
    end
  end

  // Popcount of the next busy vector so the registered count tracks busy exactly.
  always_comb begin
    w_count_next = '0;
    for (int r = 0; r < NREGS; r++) begin
      w_count_next = w_count_next + CW'(w_busy_next[r]);
    end
  end

  // State update; reset discards pending allocations and clears all data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        r_data[r] <= '0;
      end
      r_busy  <= '0;
      r_count <= '0;
    end else begin
      if (wb_valid) begin
        r_data[wb_dest] <= wb_data;
      end
      r_busy  <= w_busy_next;
      r_count <= w_count_next;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed self-checking bench for regfile_sb.
module tb_regfile_sb;

  localparam int WIDTH = 16;
  localparam int NREGS = 8;
  localparam int NREAD = 3;
  localparam int AW    = 3;
  localparam int CW    = 4;

  logic                   clk;
  logic                   rst_n;
  logic [NREAD*AW-1:0]    rd_addr;
  logic [NREAD*WIDTH-1:0] rd_data;
  logic [NREAD-1:0]       rd_busy;
  logic                   alloc_valid;
  logic [AW-1:0]          alloc_dest;
  logic                   alloc_ok;
  logic                   wb_valid;
  logic [AW-1:0]          wb_dest;
  logic [WIDTH-1:0]       wb_data;
  logic [CW-1:0]          busy_count;

  int n_checks = 0;
  int n_errors = 0;

  regfile_sb #(.WIDTH(WIDTH), .NREGS(NREGS), .NREAD(NREAD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .alloc_valid (alloc_valid),
    .alloc_dest  (alloc_dest),
    .alloc_ok    (alloc_ok),
    .wb_valid    (wb_valid),
    .wb_dest     (wb_dest),
    .wb_data     (wb_data),
    .busy_count  (busy_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int a0, input int a1, input int a2);
    rd_addr = {AW'(a2), AW'(a1), AW'(a0)};
  endtask

  task automatic idle();
    alloc_valid = 1'b0;
    alloc_dest  = '0;
    wb_valid    = 1'b0;
    wb_dest     = '0;
    wb_data     = '0;
  endtask

  function automatic logic [31:0] port_data(input int p);
    return 32'(rd_data[p*WIDTH +: WIDTH]);
  endfunction

  // Read every register on every port and compare data/busy with expectations.
  task automatic check_all_regs(input string tag, input logic [WIDTH-1:0] exp_data,
                                input logic exp_busy);
    for (int r = 0; r < NREGS; r++) begin
      set_rd(r, r, r);
      #1;
      for (int p = 0; p < NREAD; p++) begin
        check($sformatf("%s_data_r%0d_p%0d", tag, r, p), port_data(p), 32'(exp_data));
        check($sformatf("%s_busy_r%0d_p%0d", tag, r, p), 32'(rd_busy[p]), 32'(exp_busy));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_rd(0, 0, 0);
    idle();
    tick();
    rst_n = 1'b1;

    // 1. reset defaults
    $display("txn reset defaults");
    check("reset_count", 32'(busy_count), 32'd0);
    check_all_regs("reset", 16'h0000, 1'b0);

    // 2. write with same-cycle bypass, then array read
    $display("txn write r3=0xBEEF with bypass");
    wb_valid = 1'b1; wb_dest = 3'd3; wb_data = 16'hBEEF;
    set_rd(3, 0, 1);
    #1;
    check("bypass_p0", port_data(0), 32'hBEEF);
    check("bypass_p1_other", port_data(1), 32'h0000);
    tick();
    idle();
    set_rd(3, 3, 3);
    #1;
    check("stored_p0", port_data(0), 32'hBEEF);
    check("stored_p1", port_data(1), 32'hBEEF);
    check("stored_p2", port_data(2), 32'hBEEF);

    // 3. scoreboard life cycle on r5
    $display("txn alloc r5");
    alloc_valid = 1'b1; alloc_dest = 3'd5;
    #1;
    check("life_alloc_ok", 32'(alloc_ok), 32'd1);
    tick();
    idle();
    set_rd(5, 0, 5);
    #1;
    check("life_count1", 32'(busy_count), 32'd1);
    check("life_busy_c1_p0", 32'(rd_busy[0]), 32'd1);
    check("life_busy_c1_p1", 32'(rd_busy[1]), 32'd0);
    tick();
    check("life_busy_c2_p2", 32'(rd_busy[2]), 32'd1);
    $display("txn wb r5=0x1234");
    wb_valid = 1'b1; wb_dest = 3'd5; wb_data = 16'h1234;
    #1;
    check("life_wb_busy", 32'(rd_busy[0]), 32'd0);
    check("life_wb_data", port_data(0), 32'h1234);
    tick();
    idle();
    #1;
    check("life_count0", 32'(busy_count), 32'd0);
    check("life_after_busy", 32'(rd_busy[0]), 32'd0);
    check("life_after_data", port_data(0), 32'h1234);

    // 4. WAW rejection and same-cycle resolution on r2
    $display("txn alloc r2");
    alloc_valid = 1'b1; alloc_dest = 3'd2;
    tick();
    check("waw_count1", 32'(busy_count), 32'd1);
    $display("txn alloc r2 again (WAW)");
    #1;
    check("waw_reject", 32'(alloc_ok), 32'd0);
    tick();
    idle();
    set_rd(2, 2, 2);
    #1;
    check("waw_count_held", 32'(busy_count), 32'd1);
    check("waw_still_busy", 32'(rd_busy[0]), 32'd1);
    $display("txn alloc r2 + wb r2=0xA5A5");
    alloc_valid = 1'b1; alloc_dest = 3'd2;
    wb_valid = 1'b1; wb_dest = 3'd2; wb_data = 16'hA5A5;
    #1;
    check("waw_resolve_ok", 32'(alloc_ok), 32'd1);
    check("waw_resolve_rdbusy", 32'(rd_busy[1]), 32'd0);
    tick();
    idle();
    #1;
    check("waw_resolve_count", 32'(busy_count), 32'd1);
    check("waw_resolve_busy", 32'(rd_busy[0]), 32'd1);
    check("waw_resolve_data", port_data(2), 32'hA5A5);

    // 5. fill all registers (r2 already busy, so its alloc is rejected)
    for (int r = 0; r < NREGS; r++) begin
      $display("txn fill alloc r%0d", r);
      alloc_valid = 1'b1; alloc_dest = AW'(r);
      #1;
      check($sformatf("fill_ok_r%0d", r), 32'(alloc_ok), (r == 2) ? 32'd0 : 32'd1);
      tick();
    end
    idle();
    #1;
    check("fill_count8", 32'(busy_count), 32'd8);
    for (int r = 0; r < NREGS; r++) begin
      alloc_valid = 1'b1; alloc_dest = AW'(r);
      #1;
      check($sformatf("full_reject_r%0d", r), 32'(alloc_ok), 32'd0);
    end
    tick();
    idle();
    check("full_count_held", 32'(busy_count), 32'd8);

    // 6. reset mid-operation
    $display("txn reset, then set up r1/r4 busy with data");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wb_valid = 1'b1; wb_dest = 3'd1; wb_data = 16'h1111;
    tick();
    wb_dest = 3'd4; wb_data = 16'h4444;
    tick();
    idle();
    alloc_valid = 1'b1; alloc_dest = 3'd1;
    tick();
    alloc_dest = 3'd4;
    tick();
    idle();
    set_rd(1, 4, 0);
    #1;
    check("mid_pre_count", 32'(busy_count), 32'd2);
    check("mid_pre_data1", port_data(0), 32'h1111);
    check("mid_pre_data4", port_data(1), 32'h4444);
    check("mid_pre_busy4", 32'(rd_busy[1]), 32'd1);
    $display("txn reset with simultaneous alloc r6 and wb r7");
    rst_n = 1'b0;
    alloc_valid = 1'b1; alloc_dest = 3'd6;
    wb_valid = 1'b1; wb_dest = 3'd7; wb_data = 16'hFFFF;
    tick();
    rst_n = 1'b1;
    idle();
    #1;
    check("mid_post_count", 32'(busy_count), 32'd0);
    check_all_regs("mid_post", 16'h0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
